multi_compare_timer: RTL and testbench
======================================

# multi_compare_timer

Multi-channel compare/interrupt timer peripheral on the 32-bit memory-mapped IO bus. It watches the free-running system timer value `timer_in`, raises sticky per-channel pending flags on compare matches, and drives a combined interrupt line. Each channel can fire once (one-shot) or re-arm itself by adding a period to its compare value (periodic).

## Interface
- `CHANNELS`, 4: number of compare channels, 1..15.
- `WIDTH`, 32: width of `timer_in` and of the compare/period registers, 1..32. Reads are zero-extended to 32 bits.

- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `data_io`  inout  32: bidirectional bus data.
- `cs_en`  in  1: chip select.
- `wt_en`  in  1: write strobe. A write occurs at `posedge clk` when `cs_en && wt_en`.
- `rd_en`  in  1: read strobe. `data_io` is driven only when `cs_en && rd_en && !wt_en`; otherwise it is high-Z.
- `addr_in`  in  6: register address. `[5:2]` is the channel index; `[1:0]` is the register within the channel.
- `timer_in`  in  WIDTH: system timer value, synchronous to `clk`.
- `irq`  out  1: `|(pending & ie)`.
- `irq_vec`  out  CHANNELS: per-channel `pending & ie`.

## Operation
- **Channel registers** (index n < CHANNELS):
  - reg 0 COMPARE: R/W.
  - reg 1 PERIOD: R/W.
  - reg 2 CTRL: R/W. bit0 EN, bit1 IE, bit2 AUTO; other bits read 0.
  - reg 3 CAPTURE: see Configuration.
- **Global registers** (index 4'hF):
  - reg 0 PENDING: `[CHANNELS-1:0]`, read; write-1-to-clear.
  - reg 1 OVERRUN: `[CHANNELS-1:0]`, read; write-1-to-clear.
  - reg 2 ID: read-only, `{16'h4D54, 8'(WIDTH), 8'(CHANNELS)}`.
- Unmapped addresses and channel indices ≥ CHANNELS read 0; writes to them are ignored.
- **Match:** a channel matches in a cycle when `EN && timer_in == COMPARE`. On the match edge:
  - PENDING[n] is set.
  - If PENDING[n] was already 1, OVERRUN[n] is set.
  - If AUTO=1 and PERIOD≠0: COMPARE ← (COMPARE + PERIOD) mod 2^WIDTH, and EN stays 1.
  - Otherwise (one-shot, including AUTO with PERIOD=0): EN is cleared. This guarantees exactly one event per programmed match even if `timer_in` holds its value for several cycles.
- **Channel state per clock:** IDLE (EN=0) → ARMED (EN=1, by write) → on match: ARMED (periodic) or IDLE (one-shot).
- **Simultaneous events:**
  - Software write to COMPARE/PERIOD/CTRL in the same cycle as a match on that channel: the match is evaluated against the old values and PENDING is set; the software write wins for the written register, and the auto-update/EN-clear is discarded for that register.
  - W1C of PENDING[n] in the same cycle as a new match on n: PENDING[n] stays 1 and OVERRUN[n] is not set (the clear acknowledges the old event).
  - W1C of OVERRUN in the same cycle as a new overrun: set wins.
- **Reset:** all registers 0. `irq`=0, `irq_vec`=0, `data_io` high-Z. Reset mid-operation aborts all armed channels immediately (asynchronously).

## Timing
- Write takes effect at the capturing `posedge`. The new COMPARE value participates in matching from the next cycle.
- Read data is combinational from the address; it is valid in the same cycle as `cs_en && rd_en`.
- Match to PENDING: the same edge where the match is sampled. `irq`/`irq_vec` rise combinationally from the registered PENDING, i.e. 1 cycle after the cycle `timer_in` equals COMPARE.
- W1C of PENDING drops `irq` in the cycle after the write edge, unless another pending enabled channel remains.
- Clearing IE masks `irq_vec[n]` without clearing PENDING[n].

## Configuration
- Macro `MULTI_COMPARE_TIMER_CAPTURE_EN`.
- **Defined:** each channel has a WIDTH-bit CAPTURE register (reg 3, read-only) loaded with `timer_in` on every match edge. It resets to 0; writes are ignored.
- **Undefined:** no capture storage; reg 3 reads 0.

## Test plan
- **One-shot:** CH0 COMPARE=100, CTRL=3; `timer_in` ramps 98..103, holding 100 for 3 cycles -> PENDING=1 once, `irq` high 1 cycle after the first 100, CTRL.EN=0, OVERRUN=0.
- **Periodic with wrap:** WIDTH=32, CH1 COMPARE=32'hFFFF_FFF0, PERIOD=32, CTRL=7 -> after match, COMPARE=32'h0000_0010. With PENDING cleared between events, it fires again at 0x10 and COMPARE becomes 0x30.
- **Overrun and mask:** CH2 periodic, PERIOD=5, IE=0, no clear -> after 2 matches PENDING[2]=1, OVERRUN[2]=1, `irq`=0. Setting IE=1 -> `irq`=1. W1C 4'b0100 to both registers -> both 0, `irq`=0.
- **Simultaneous clear and match:** W1C PENDING[0] on the match edge of CH0 -> PENDING[0]=1, OVERRUN[0]=0. A write COMPARE=500 on a match edge -> COMPARE reads 500 and PENDING is set.
- **Bus/reset:** reads with `cs_en`=0 or `wt_en`=1 -> `data_io` high-Z; channel index ≥ CHANNELS reads 0. ID read returns 32'h4D54_2004 for the defaults. Asserting `rst` while channels are armed -> all registers 0 and `irq`=0 asynchronously.
- **Capture (macro on):** match at `timer_in`=100 -> CAPTURE reads 100; a write to reg 3 has no effect. With the macro off, reg 3 reads 0.

Source files
------------

// File: rtl/multi_compare_timer.sv
// multi_compare_timer
//   Multi-channel compare/interrupt timer on the 32-bit memory-mapped bus.
//   Each channel compares the free-running timer_in against its COMPARE
//   register; a match sets a sticky PENDING bit (and OVERRUN if PENDING was
//   already set). A channel is either one-shot (EN clears on match) or
//   periodic (COMPARE advances by PERIOD and EN stays set).
//
//   Optional feature macro: MULTI_COMPARE_TIMER_CAPTURE_EN
//     defined   -> per-channel CAPTURE register (reg 3) latches timer_in on
//                  every match edge; read-only.
//     undefined -> reg 3 reads 0, no capture storage.
//
// Ports
//   clk       in     system clock
//   rst       in     asynchronous active-high reset
//   data_io   inout  32-bit bus data, driven only during a read
//   cs_en     in     chip select
//   wt_en     in     write strobe (write at posedge when cs_en && wt_en)
//   rd_en     in     read strobe (drive when cs_en && rd_en && !wt_en)
//   addr_in   in     [5:2] channel index (4'hF = global), [1:0] register
//   timer_in  in     system timer value
//   irq       out    OR of irq_vec
//   irq_vec   out    per-channel PENDING & IE
//
// Register map (per channel n): 0 COMPARE, 1 PERIOD, 2 CTRL{AUTO,IE,EN}, 3 CAPTURE
// Global (index 4'hF): 0 PENDING (W1C), 1 OVERRUN (W1C), 2 ID

module multi_compare_timer #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 32
) (
   input  logic                clk,
   input  logic                rst,
   inout  wire  [31:0]         data_io,
   input  logic                cs_en,
   input  logic                wt_en,
   input  logic                rd_en,
   input  logic [5:0]          addr_in,
   input  logic [WIDTH-1:0]    timer_in,
   output logic                irq,
   output logic [CHANNELS-1:0] irq_vec
);

   localparam logic [3:0]  GLB_IDX = 4'hF;
   localparam logic [31:0] ID_VAL  = {16'h4D54, 8'(WIDTH), 8'(CHANNELS)};

   logic [WIDTH-1:0]    r_cmp [CHANNELS];
   logic [WIDTH-1:0]    r_per [CHANNELS];
   logic [CHANNELS-1:0] r_en;
   logic [CHANNELS-1:0] r_ie;
   logic [CHANNELS-1:0] r_auto;
   logic [CHANNELS-1:0] r_pend;
   logic [CHANNELS-1:0] r_ovr;
`ifdef MULTI_COMPARE_TIMER_CAPTURE_EN
   logic [WIDTH-1:0]    r_cap [CHANNELS];
`endif

   logic [3:0]          w_ch;
   logic [1:0]          w_reg;
   logic                w_wr;
   logic                w_rd_oe;
   logic [31:0]         w_wdata;
   logic [31:0]         w_rdata;
   logic                w_glb_sel;
   logic [CHANNELS-1:0] w_match;
   logic [CHANNELS-1:0] w_reload;
   logic [CHANNELS-1:0] w_ch_sel;
   logic [CHANNELS-1:0] w_pend_clr;
   logic [CHANNELS-1:0] w_ovr_clr;

   assign w_ch      = addr_in[5:2];
   assign w_reg     = addr_in[1:0];
   assign w_wr      = cs_en && wt_en;
   assign w_rd_oe   = cs_en && rd_en && !wt_en;
   assign w_wdata   = data_io;
   assign w_glb_sel = w_wr && (w_ch == GLB_IDX);

   assign w_pend_clr = (w_glb_sel && (w_reg == 2'd0)) ? w_wdata[CHANNELS-1:0] : '0;
   assign w_ovr_clr  = (w_glb_sel && (w_reg == 2'd1)) ? w_wdata[CHANNELS-1:0] : '0;

   // Match and reload decisions always use the values held before this edge,
   // so a same-cycle software write cannot change whether this edge fires.
   always_comb begin
      w_match  = '0;
      w_reload = '0;
      w_ch_sel = '0;
      for (int n = 0; n < CHANNELS; n++) begin
         w_match[n]  = r_en[n] && (timer_in == r_cmp[n]);
         w_reload[n] = r_auto[n] && (r_per[n] != '0);
         w_ch_sel[n] = w_wr && (w_ch == 4'(n));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_en   <= '0;
         r_ie   <= '0;
         r_auto <= '0;
         r_pend <= '0;
         r_ovr  <= '0;
         for (int n = 0; n < CHANNELS; n++) begin
            r_cmp[n] <= '0;
            r_per[n] <= '0;
`ifdef MULTI_COMPARE_TIMER_CAPTURE_EN
            r_cap[n] <= '0;
`endif
         end
      end else begin
         for (int n = 0; n < CHANNELS; n++) begin
            // Software write to COMPARE wins over the periodic advance.
            if (w_ch_sel[n] && (w_reg == 2'd0))
               r_cmp[n] <= w_wdata[WIDTH-1:0];
            else if (w_match[n] && w_reload[n])
               r_cmp[n] <= r_cmp[n] + r_per[n];

            if (w_ch_sel[n] && (w_reg == 2'd1))
               r_per[n] <= w_wdata[WIDTH-1:0];

            // Software write to CTRL wins over the one-shot EN clear.
            if (w_ch_sel[n] && (w_reg == 2'd2)) begin
               r_en[n]   <= w_wdata[0];
               r_ie[n]   <= w_wdata[1];
               r_auto[n] <= w_wdata[2];
            end else if (w_match[n] && !w_reload[n]) begin
               r_en[n] <= 1'b0;
            end

            // A clear arriving with a new match acknowledges the old event,
            // so it neither drops PENDING nor counts as an overrun.
            r_pend[n] <= (r_pend[n] & ~w_pend_clr[n]) | w_match[n];
            r_ovr[n]  <= (r_ovr[n] & ~w_ovr_clr[n])
                       | (w_match[n] & r_pend[n] & ~w_pend_clr[n]);

`ifdef MULTI_COMPARE_TIMER_CAPTURE_EN
            if (w_match[n])
               r_cap[n] <= timer_in;
`endif
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      if (w_ch == GLB_IDX) begin
         case (w_reg)
            2'd0:    w_rdata = 32'(r_pend);
            2'd1:    w_rdata = 32'(r_ovr);
            2'd2:    w_rdata = ID_VAL;
            default: w_rdata = '0;
         endcase
      end else begin
         for (int n = 0; n < CHANNELS; n++) begin
            if (w_ch == 4'(n)) begin
               case (w_reg)
                  2'd0:    w_rdata = 32'(r_cmp[n]);
                  2'd1:    w_rdata = 32'(r_per[n]);
                  2'd2:    w_rdata = {29'd0, r_auto[n], r_ie[n], r_en[n]};
`ifdef MULTI_COMPARE_TIMER_CAPTURE_EN
                  2'd3:    w_rdata = 32'(r_cap[n]);
`endif
                  default: w_rdata = '0;
               endcase
            end
         end
      end
   end

   assign data_io = w_rd_oe ? w_rdata : 32'hzzzz_zzzz;
   assign irq_vec = r_pend & r_ie;
   assign irq     = |irq_vec;

endmodule

// File: tb/tb_multi_compare_timer.sv
// Scoreboard bench for multi_compare_timer: stimulus queues expected values,
// a negedge monitor pops and compares whatever the stimulus asked it to watch.
module tb_multi_compare_timer;

   localparam int CH = 4;
   localparam int W  = 32;

   localparam int K_BUS = 0;
   localparam int K_IRQ = 1;
   localparam int K_VEC = 2;
   localparam int K_HIZ = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cs_en = 1'b0;
   logic          wt_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [5:0]    addr_in = '0;
   logic [W-1:0]  timer_in = '0;
   logic          tb_oe = 1'b0;
   logic [31:0]   tb_d = '0;
   wire  [31:0]   data_io;
   logic          irq;
   logic [CH-1:0] irq_vec;

   assign data_io = tb_oe ? tb_d : 32'hzzzz_zzzz;

   multi_compare_timer #(.CHANNELS(CH), .WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .data_io  (data_io),
      .cs_en    (cs_en),
      .wt_en    (wt_en),
      .rd_en    (rd_en),
      .addr_in  (addr_in),
      .timer_in (timer_in),
      .irq      (irq),
      .irq_vec  (irq_vec)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   logic chk_stb = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

`ifdef MULTI_COMPARE_TIMER_CAPTURE_EN
   localparam logic [31:0] CAP_EXP = 32'd510;
`else
   localparam logic [31:0] CAP_EXP = 32'd0;
`endif

   // Monitor
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      if (chk_stb) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_underflow: observation requested with no expected entry");
         end else begin
            e = sb.pop_front();
            case (e.kind)
               K_BUS:   act = data_io;
               K_IRQ:   act = {31'd0, irq};
               K_VEC:   act = 32'(irq_vec);
               default: act = (data_io === 32'hzzzz_zzzz) ? 32'd1 : 32'd0;
            endcase
            if (act !== e.exp) begin
               n_bad++;
               $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
         end
      end
   end

   task automatic obs(input int kind, input logic [31:0] exp, input string name);
      exp_t e;
      e.name = name;
      e.kind = kind;
      e.exp  = exp;
      sb.push_back(e);
      chk_stb = 1'b1;
      @(posedge clk);
      #1;
      chk_stb = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      cs_en   = 1'b1;
      wt_en   = 1'b1;
      addr_in = a;
      tb_d    = d;
      tb_oe   = 1'b1;
      @(posedge clk);
      #1;
      cs_en = 1'b0;
      wt_en = 1'b0;
      tb_oe = 1'b0;
   endtask

   task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string name);
      cs_en   = 1'b1;
      rd_en   = 1'b1;
      addr_in = a;
      obs(K_BUS, exp, name);
      cs_en = 1'b0;
      rd_en = 1'b0;
   endtask

   typedef struct {
      logic [31:0] t;
      logic        irq_exp;
   } ramp_t;

   ramp_t ramp[8] = '{
      '{32'd98, 1'b0}, '{32'd99, 1'b0}, '{32'd100, 1'b0}, '{32'd100, 1'b1},
      '{32'd100, 1'b1}, '{32'd101, 1'b1}, '{32'd102, 1'b1}, '{32'd103, 1'b1}
   };

   initial begin
      // Reset state
      tick();
      tick();
      obs(K_IRQ, 32'd0, "rst_irq");
      obs(K_VEC, 32'd0, "rst_vec");
      obs(K_HIZ, 32'd1, "rst_hiz");
      rst = 1'b0;
      tick();
      rd(6'h02, 32'd0, "rst_ctrl0");
      rd(6'h3C, 32'd0, "rst_pending");
      rd(6'h3E, 32'h4D54_2004, "id");

      // Bus behaviour
      cs_en = 1'b0; rd_en = 1'b1; addr_in = 6'h3E;
      obs(K_HIZ, 32'd1, "hiz_no_cs");
      cs_en = 1'b1; rd_en = 1'b1; wt_en = 1'b1;
      obs(K_HIZ, 32'd1, "hiz_wt");
      cs_en = 1'b0; rd_en = 1'b0; wt_en = 1'b0;
      wr(6'h14, 32'h1234);
      rd(6'h14, 32'd0, "ch5_cmp");
      rd(6'h3F, 32'd0, "glb_reg3");

      // One-shot on CH0
      wr(6'h00, 32'd100);
      wr(6'h02, 32'd3);
      for (int i = 0; i < 8; i++) begin
         timer_in = ramp[i].t;
         obs(K_IRQ, {31'd0, ramp[i].irq_exp}, $sformatf("oneshot_irq_%0d", i));
      end
      rd(6'h3C, 32'd1, "oneshot_pending");
      rd(6'h3D, 32'd0, "oneshot_overrun");
      rd(6'h02, 32'd2, "oneshot_ctrl");
      wr(6'h3C, 32'd1);
      obs(K_IRQ, 32'd0, "oneshot_w1c_irq");

      // Periodic with wrap on CH1
      wr(6'h04, 32'hFFFF_FFF0);
      wr(6'h05, 32'd32);
      wr(6'h06, 32'd7);
      timer_in = 32'hFFFF_FFF0;
      tick();
      rd(6'h04, 32'h0000_0010, "wrap_cmp1");
      rd(6'h3C, 32'd2, "wrap_pending1");
      rd(6'h06, 32'd7, "wrap_ctrl");
      wr(6'h3C, 32'd2);
      timer_in = 32'h10;
      tick();
      rd(6'h04, 32'h0000_0030, "wrap_cmp2");
      rd(6'h3C, 32'd2, "wrap_pending2");
      rd(6'h3D, 32'd0, "wrap_overrun");
      obs(K_VEC, 32'd2, "wrap_vec");
      wr(6'h06, 32'd0);
      wr(6'h3C, 32'd2);

      // Overrun and mask on CH2
      timer_in = 32'd0;
      wr(6'h08, 32'd10);
      wr(6'h09, 32'd5);
      wr(6'h0A, 32'd5);
      timer_in = 32'd10;
      tick();
      timer_in = 32'd15;
      tick();
      rd(6'h3C, 32'd4, "ovr_pending");
      rd(6'h3D, 32'd4, "ovr_overrun");
      rd(6'h08, 32'd20, "ovr_cmp");
      obs(K_IRQ, 32'd0, "ovr_masked_irq");
      wr(6'h0A, 32'd7);
      obs(K_IRQ, 32'd1, "ovr_ie_irq");
      obs(K_VEC, 32'd4, "ovr_ie_vec");
      wr(6'h0A, 32'd5);
      obs(K_IRQ, 32'd0, "ovr_remask_irq");
      rd(6'h3C, 32'd4, "ovr_remask_pending");
      wr(6'h0A, 32'd6);
      obs(K_IRQ, 32'd1, "ovr_ie2_irq");
      wr(6'h3C, 32'd4);
      wr(6'h3D, 32'd4);
      rd(6'h3C, 32'd0, "ovr_clr_pending");
      rd(6'h3D, 32'd0, "ovr_clr_overrun");
      obs(K_IRQ, 32'd0, "ovr_clr_irq");

      // Simultaneous events on CH0
      timer_in = 32'd0;
      wr(6'h00, 32'd200);
      wr(6'h01, 32'd10);
      wr(6'h02, 32'd7);
      timer_in = 32'd200;
      tick();
      timer_in = 32'd210;
      wr(6'h3C, 32'd1);
      timer_in = 32'd215;
      rd(6'h3C, 32'd1, "sim_clr_pending");
      rd(6'h3D, 32'd0, "sim_clr_overrun");
      rd(6'h00, 32'd220, "sim_clr_cmp");
      wr(6'h3C, 32'd1);
      timer_in = 32'd220;
      wr(6'h00, 32'd500);
      timer_in = 32'd221;
      rd(6'h00, 32'd500, "sim_wr_cmp");
      rd(6'h3C, 32'd1, "sim_wr_pending");
      rd(6'h3D, 32'd0, "sim_wr_overrun");
      rd(6'h02, 32'd7, "sim_wr_ctrl");
      timer_in = 32'd500;
      tick();
      timer_in = 32'd510;
      wr(6'h3D, 32'd1);
      timer_in = 32'd511;
      rd(6'h3D, 32'd1, "sim_ovr_setwins");

      // Capture register
      rd(6'h03, CAP_EXP, "capture");
      wr(6'h03, 32'hABCD);
      rd(6'h03, CAP_EXP, "capture_wr_ignored");
      wr(6'h02, 32'd0);
      wr(6'h3C, 32'd1);
      wr(6'h3D, 32'd1);

      // AUTO with PERIOD=0 behaves as one-shot on CH3
      timer_in = 32'd0;
      wr(6'h0C, 32'd300);
      wr(6'h0D, 32'd0);
      wr(6'h0E, 32'd7);
      timer_in = 32'd300;
      tick();
      tick();
      rd(6'h0E, 32'd6, "p0_ctrl");
      rd(6'h3C, 32'd8, "p0_pending");
      rd(6'h3D, 32'd0, "p0_overrun");
      rd(6'h0C, 32'd300, "p0_cmp");

      // Asynchronous reset while armed
      timer_in = 32'd0;
      wr(6'h04, 32'd1000);
      wr(6'h06, 32'd3);
      obs(K_IRQ, 32'd1, "pre_rst_irq");
      #1;
      rst = 1'b1;
      obs(K_IRQ, 32'd0, "rst_async_irq");
      rst = 1'b0;
      rd(6'h3C, 32'd0, "post_rst_pending");
      rd(6'h06, 32'd0, "post_rst_ctrl1");
      rd(6'h04, 32'd0, "post_rst_cmp1");
      obs(K_VEC, 32'd0, "post_rst_vec");

      tick();
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL sb_leftover: %0d entries left, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
